// File: rtl/carloni_pkg.sv
// Shared types for the Carloni relay station: state encoding and the
// illegal {Mv,Av} combination checked by assertions.
package carloni_pkg;

  typedef enum logic [1:0] {RS_EMPTY, RS_HALF, RS_FULL} carloni_rs_state_t;

  // {Mv, Av} = {0, 1}: auxiliary register valid without a main token.
  localparam logic [1:0] RS_ILLEGAL_MV_AV = 2'b01;

  function automatic carloni_rs_state_t rs_state(input logic mv, input logic av);
    carloni_rs_state_t st;
    case ({mv, av})
      2'b10:   st = RS_HALF;
      2'b11:   st = RS_FULL;
      default: st = RS_EMPTY;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/carloni_relay_station.sv
// Two-register relay station for the void/stop latency-insensitive protocol:
// main register M drives downstream, auxiliary register A absorbs the one
// token of slack caused by the registered upstream stop.
module carloni_relay_station
  import carloni_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_void,
  output logic             o_stop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_void,
  input  logic             i_stop,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  m_q, m_d, a_q, a_d;
  logic              void_q, void_d, av_q, av_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mv_c, acc_c, cons_c;
  carloni_rs_state_t state_c;

  // M's valid bit is kept inverted so o_void comes straight off a flop.
  assign mv_c    = ~void_q;
  assign state_c = rs_state(mv_c, av_q);
  assign acc_c   = ~i_void & ~av_q;
  assign cons_c  = mv_c & ~i_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q    <= '0;
      a_q    <= '0;
      void_q <= 1'b1;
      av_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      m_q    <= m_d;
      a_q    <= a_d;
      void_q <= void_d;
      av_q   <= av_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    m_d    = m_q;
    a_d    = a_q;
    void_d = void_q;
    av_d   = av_q;
    cnt_d  = cnt_q;

    if (state_c == RS_FULL && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_c)
      RS_EMPTY: begin
        if (acc_c) begin
          m_d    = i_data;
          void_d = 1'b0;
        end
      end
      RS_HALF: begin
        if (acc_c && cons_c) begin
          m_d = i_data;
        end else if (acc_c) begin
          a_d  = i_data;
          av_d = 1'b1;
        end else if (cons_c) begin
          void_d = 1'b1;
        end
      end
      RS_FULL: begin
        // Upstream is stopped, so only a downstream consume can move data.
        if (cons_c) begin
          m_d  = a_q;
          av_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_data      = m_q;
  assign o_void      = void_q;
  assign o_stop      = av_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_carloni_relay_station.sv
// Bench for carloni_relay_station: directed scenarios plus randomized traffic
// checked against a queue model of the station's contents.
module tb_carloni_relay_station;
  import carloni_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_data;
  logic        i_void;
  logic        i_stop;
  logic        o_stop;
  logic [15:0] o_data;
  logic        o_void;
  logic [15:0] o_stall_cnt;

  logic [15:0] d4_data;
  logic        d4_void;
  logic        d4_stop;
  logic        d4_ostop;
  logic [15:0] d4_odata;
  logic        d4_ovoid;
  logic [3:0]  d4_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carloni_relay_station #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_void(i_void),
    .o_stop(o_stop), .o_data(o_data), .o_void(o_void), .i_stop(i_stop),
    .o_stall_cnt(o_stall_cnt)
  );

  carloni_relay_station #(.WIDTH(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .i_data(d4_data), .i_void(d4_void),
    .o_stop(d4_ostop), .o_data(d4_odata), .o_void(d4_ovoid), .i_stop(d4_stop),
    .o_stall_cnt(d4_cnt)
  );

  a_legal: assert property (@(posedge clk) disable iff (reset)
    {~o_void, o_stop} != RS_ILLEGAL_MV_AV)
    else $error("FAIL assert_legal_state void=%0b stop=%0b", o_void, o_stop);

  a_no_acc: assert property (@(posedge clk) disable iff (reset)
    o_stop |-> !dut.acc_c)
    else $error("FAIL assert_no_accept_while_stop");

  a_hold: assert property (@(posedge clk) disable iff (reset)
    (o_stop && !i_void) |=> (!i_void && $stable(i_data)))
    else $error("FAIL assert_upstream_hold data=%h", i_data);

  // Reference model: the station is a FIFO of at most two tokens; stop is
  // asserted whenever it holds two, and o_data shows the last front token.
  logic [15:0] mq[$];
  logic [15:0] m_last;
  int unsigned m_cnt;
  bit          m_full, m_cons, m_acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_last = 16'h0;
      m_cnt  = 0;
    end else begin
      m_full = (mq.size() == 2);
      m_cons = (mq.size() > 0) && !i_stop;
      m_acc  = !i_void && (mq.size() < 2);
      if (m_full && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_cons) void'(mq.pop_front());
      if (m_acc) mq.push_back(i_data);
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    i_void = 1'b1;
    i_stop = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset  = 1'b1;
    i_void = 1'b1;
    i_stop = 1'b0;
    #1;
    checks++; if (o_void !== 1'b1) begin errors++; $display("FAIL reset_void got=%0b exp=1", o_void); end
    checks++; if (o_stop !== 1'b0) begin errors++; $display("FAIL reset_stop got=%0b exp=0", o_stop); end
    checks++; if (o_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", o_data); end
    checks++; if (o_stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_stall_cnt); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (o_void !== 1'b1 || o_stop !== 1'b0 || o_stall_cnt !== 16'h0) begin
        errors++; $display("FAIL idle cyc=%0d void=%0b stop=%0b cnt=%0d exp void=1 stop=0 cnt=0", c, o_void, o_stop, o_stall_cnt);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    i_stop = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      i_data = 16'(k);
      i_void = 1'b0;
      @(negedge clk);
      checks++; if (o_data !== 16'(k) || o_void !== 1'b0 || o_stop !== 1'b0) begin
        errors++; $display("FAIL stream k=%0d data=%h void=%0b stop=%0b exp data=%h void=0 stop=0", k, o_data, o_void, o_stop, 16'(k));
      end
    end
    i_void = 1'b1;
    @(negedge clk);
    checks++; if (o_void !== 1'b1) begin errors++; $display("FAIL stream_drain void=%0b exp=1", o_void); end
  endtask

  task automatic test_backpressure();
    logic [15:0] td[7];
    logic        tv[7], ts[7], ev[7], es[7];
    logic [15:0] ed[7], ec[7];
    td = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A2, 16'h00A2, 16'h00A2, 16'h00A2};
    tv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ed = '{16'h00A0, 16'h00A0, 16'h00A0, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A2};
    ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    es = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ec = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
    do_reset();
    for (int s = 0; s < 7; s++) begin
      i_data = td[s];
      i_void = tv[s];
      i_stop = ts[s];
      @(negedge clk);
      checks++; if (o_data !== ed[s] || o_void !== ev[s] || o_stop !== es[s] || o_stall_cnt !== ec[s]) begin
        errors++; $display("FAIL backpressure step=%0d data=%h void=%0b stop=%0b cnt=%0d exp data=%h void=%0b stop=%0b cnt=%0d",
                           s, o_data, o_void, o_stop, o_stall_cnt, ed[s], ev[s], es[s], ec[s]);
      end
    end
    i_stop = 1'b0;
  endtask

  task automatic test_stop_while_void();
    do_reset();
    i_stop = 1'b1;
    i_void = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (o_void !== 1'b1 || o_stop !== 1'b0) begin
        errors++; $display("FAIL stopvoid_idle void=%0b stop=%0b exp void=1 stop=0", o_void, o_stop);
      end
    end
    i_data = 16'h1234;
    i_void = 1'b0;
    @(negedge clk);
    checks++; if (o_data !== 16'h1234 || o_void !== 1'b0 || o_stop !== 1'b0) begin
      errors++; $display("FAIL stopvoid_accept data=%h void=%0b stop=%0b exp data=1234 void=0 stop=0", o_data, o_void, o_stop);
    end
    i_void = 1'b1;
    @(negedge clk);
    checks++; if (o_data !== 16'h1234 || o_void !== 1'b0 || o_stop !== 1'b0 || o_stall_cnt !== 16'h0) begin
      errors++; $display("FAIL stopvoid_hold data=%h void=%0b stop=%0b cnt=%0d exp data=1234 void=0 stop=0 cnt=0", o_data, o_void, o_stop, o_stall_cnt);
    end
    i_stop = 1'b0;
    @(negedge clk);
    checks++; if (o_void !== 1'b1) begin errors++; $display("FAIL stopvoid_drain void=%0b exp=1", o_void); end
  endtask

  task automatic test_reset_full();
    do_reset();
    i_stop = 1'b1;
    i_data = 16'h0011;
    i_void = 1'b0;
    @(negedge clk);
    i_data = 16'h0022;
    @(negedge clk);
    checks++; if (o_stop !== 1'b1 || o_data !== 16'h0011) begin
      errors++; $display("FAIL rstfull_full stop=%0b data=%h exp stop=1 data=0011", o_stop, o_data);
    end
    i_void = 1'b1;
    @(negedge clk);
    checks++; if (o_stall_cnt !== 16'd1) begin errors++; $display("FAIL rstfull_cnt got=%0d exp=1", o_stall_cnt); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (o_void !== 1'b1 || o_stop !== 1'b0 || o_stall_cnt !== 16'h0 || o_data !== 16'h0) begin
      errors++; $display("FAIL rstfull_async void=%0b stop=%0b cnt=%0d data=%h exp void=1 stop=0 cnt=0 data=0000", o_void, o_stop, o_stall_cnt, o_data);
    end
    @(negedge clk);
    reset  = 1'b0;
    i_stop = 1'b0;
    i_data = 16'h0033;
    i_void = 1'b0;
    @(negedge clk);
    checks++; if (o_data !== 16'h0033 || o_void !== 1'b0 || o_stop !== 1'b0) begin
      errors++; $display("FAIL rstfull_new data=%h void=%0b stop=%0b exp data=0033 void=0 stop=0", o_data, o_void, o_stop);
    end
    i_void = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    do_reset();
    d4_stop = 1'b1;
    d4_data = 16'h0055;
    d4_void = 1'b0;
    @(negedge clk);
    d4_data = 16'h0066;
    @(negedge clk);
    checks++; if (d4_ostop !== 1'b1) begin errors++; $display("FAIL sat_full stop=%0b exp=1", d4_ostop); end
    d4_void = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++; if (d4_cnt !== 4'((k < 15) ? k : 15)) begin
        errors++; $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, d4_cnt, (k < 15) ? k : 15);
      end
    end
    d4_stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (d4_ovoid !== 1'b1 || d4_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_drain void=%0b cnt=%0d exp void=1 cnt=15", d4_ovoid, d4_cnt);
    end
  endtask

  task automatic test_random();
    logic last_stop;
    do_reset();
    last_stop = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) begin
        @(negedge clk);
        checks++; if (o_void !== (mq.size() == 0)) begin errors++; $display("FAIL rand_void cyc=%0d got=%0b exp=%0b", c, o_void, mq.size() == 0); end
        checks++; if (o_stop !== (mq.size() == 2)) begin errors++; $display("FAIL rand_stop cyc=%0d got=%0b exp=%0b", c, o_stop, mq.size() == 2); end
        checks++; if (o_data !== m_last) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, o_data, m_last); end
        checks++; if (o_stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, o_stall_cnt, m_cnt); end
      end
      // A token refused at the last edge must be presented again unchanged.
      if (!(i_void == 1'b0 && last_stop)) begin
        if (c >= 590) i_void = 1'b1;
        else          i_void = ($urandom_range(0, 3) == 0);
        i_data = 16'($urandom);
      end
      if (c >= 580)      i_stop = 1'b0;
      else if (c < 300)  i_stop = ($urandom_range(0, 1) == 0);
      else               i_stop = ($urandom_range(0, 4) == 0);
      last_stop = o_stop;
    end
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    i_data  = 16'h0;
    i_void  = 1'b1;
    i_stop  = 1'b0;
    d4_data = 16'h0;
    d4_void = 1'b1;
    d4_stop = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_stop_while_void();
    test_reset_full();
    test_saturation();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/carloni_relay_station.md
Name: carloni_relay_station

Overview:
- Two-register Carloni relay station. It is the transmit-side and link-side counterpart of the shell input FIFO.
- Drives the void/stop latency-insensitive protocol toward a downstream shell, which asserts stop from its FIFO almost-full.
- Accepts tokens from an upstream shell or relay station and applies back-pressure upstream with a registered stop.
- Placed on long inter-shell wires to break timing paths without losing throughput.

Parameters:
WIDTH, 16, token payload width in bits
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
i_data  input  WIDTH  upstream token payload
i_void  input  1  1 = upstream token absent this cycle
o_stop  output  1  back-pressure to upstream; registered
o_data  output  WIDTH  downstream token payload
o_void  output  1  1 = no valid token on o_data
i_stop  input  1  downstream back-pressure (its FIFO almost-full)
o_stall_cnt  output  CNT_W  cycles spent in RS_FULL, saturating

Behaviour:
- Storage: main register M with valid bit Mv; auxiliary register A with valid bit Av.
- Outputs are direct register outputs: o_data = M, o_void = !Mv, o_stop = Av.
- Reset is asynchronous, active-high (clk, reset):
  - M, A cleared to 0; Mv = Av = 0.
  - o_void = 1, o_stop = 0, o_stall_cnt = 0.
  - State RS_EMPTY.
- Reset mid-operation drops all held tokens; there is no recovery of in-flight data.
- Consume event: cons = Mv & !i_stop. A token with o_void=1 is never consumed, and i_stop is ignored while o_void=1.
- Accept event: acc = !i_void & !o_stop.
  - Upstream must hold i_data/i_void unchanged while it sees o_stop=1.
  - A non-void token presented while o_stop=1 is not taken.
- State is derived from {Mv, Av}: RS_EMPTY (0,0), RS_HALF (1,0), RS_FULL (1,1). {0,1} is illegal and unreachable.
- RS_EMPTY:
  - acc: M<=i_data, Mv<=1, go RS_HALF.
  - Otherwise stay.
- RS_HALF:
  - acc & cons: M<=i_data, stay RS_HALF. This is full throughput, one token per cycle.
  - acc & !cons: A<=i_data, Av<=1, go RS_FULL. o_stop rises the next cycle.
  - !acc & cons: Mv<=0, go RS_EMPTY.
  - !acc & !cons: hold.
- RS_FULL (o_stop=1, acc impossible):
  - cons: M<=A, Av<=0, go RS_HALF. o_stop falls the next cycle.
  - !cons: hold M and A.
- Latency: a token accepted at edge t appears on o_data/o_void=0 after edge t. That is one cycle, in-order, with no loss or duplication.
- Because o_stop is registered, one token of slack is absorbed by A. The combinational path from i_stop to o_stop never exists.
- o_stall_cnt increments by 1 on every clock edge where the state is RS_FULL. It saturates at 2**CNT_W-1 and clears only on reset.
- A and M are written only on the listed transitions; otherwise they keep their value (no bubbling of void data).

Decomposition:
- Package carloni_pkg holds:
  - typedef enum logic [1:0] {RS_EMPTY, RS_HALF, RS_FULL} carloni_rs_state_t
  - a localparam for the illegal-state encoding, used by assertions
- Single module, no sub-module. The M/A datapath is too small to justify a split.
- Bench binds assertions:
  - {Mv,Av} != {0,1}
  - o_stop implies no accept
  - stable i_data while o_stop & !i_void

Test Plan:
- Reset then idle (i_void=1, i_stop=0) for 5 cycles -> o_void=1, o_stop=0, o_stall_cnt=0 throughout.
- Stream 0x0001..0x0008 on consecutive cycles with i_stop=0 -> o_data 0x0001..0x0008 one cycle later, back-to-back, o_stop never 1.
- Stream 0x00A0,0x00A1,0x00A2 with i_stop=1 from the cycle 0x00A0 appears, held 3 cycles ->
  - 0x00A1 captured in A; o_stop=1 from the next cycle.
  - Upstream holds 0x00A2.
  - o_stall_cnt=3 at release.
  - Output order 0x00A0,0x00A1,0x00A2 with no duplicates.
- i_stop=1 while o_void=1, then send 0x1234 -> 0x1234 accepted and shown next cycle; no stall.
- Reach RS_FULL holding 0x0011/0x0022, assert reset asynchronously mid-cycle -> outputs immediately o_void=1, o_stop=0, o_stall_cnt=0. After release, new token 0x0033 passes with 1-cycle latency.
- CNT_W=4, hold i_stop=1 in RS_FULL for 20 cycles -> o_stall_cnt saturates at 15 and stays there.
